// File: rtl/conv_feed_if.sv
// AXI-Stream beat bus feeding the conv window unpacker.
// tdata/tvalid/tlast from the DMA master, tready back.
interface conv_feed_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (
    output tdata, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/conv_feed.sv
// Unpacks 6 stream beats into 72-bit weight/pixel vectors for the 3x3 core.
// Ports: s_axis (stream slave), w/p + strobes to core, res_valid back, status.
module conv_feed #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  conv_feed_if.slave       s_axis,
  output logic [71:0]      w,
  output logic             w_valid,
  output logic [71:0]      p,
  output logic             p_valid,
  output logic             p_last,
  input  logic             res_valid,
  output logic [CNT_W-1:0] win_cnt,
  output logic             frame_err
);

  typedef enum logic {RECV, WAIT} state_t;

  state_t           state_q, state_d;
  logic [2:0]       bcnt_q, bcnt_d;
  logic [63:0]      wsh_q, wsh_d;
  logic [63:0]      psh_q, psh_d;
  logic [71:0]      w_q, w_d;
  logic [71:0]      p_q, p_d;
  logic             w_valid_q, w_valid_d;
  logic             p_valid_q, p_valid_d;
  logic             p_last_q, p_last_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic             frame_err_q, frame_err_d;
  logic             tready_q, tready_d;
  logic             acc;

  assign acc = s_axis.tvalid && tready_q;

  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    wsh_d       = wsh_q;
    psh_d       = psh_q;
    w_d         = w_q;
    p_d         = p_q;
    w_valid_d   = 1'b0;
    p_valid_d   = 1'b0;
    p_last_d    = 1'b0;
    win_cnt_d   = win_cnt_q;
    frame_err_d = frame_err_q;
    unique case (state_q)
      RECV: begin
        if (acc) begin
          if (s_axis.tlast && bcnt_q != 3'd5) begin
            // early tlast: drop the partial window
            frame_err_d = 1'b1;
            bcnt_d      = 3'd0;
          end else begin
            bcnt_d = bcnt_q + 3'd1;
            unique case (bcnt_q)
              3'd0: wsh_d[31:0]  = s_axis.tdata;
              3'd1: wsh_d[63:32] = s_axis.tdata;
              3'd2: begin
                w_d       = {s_axis.tdata[7:0], wsh_q};
                w_valid_d = 1'b1;
              end
              3'd3: psh_d[31:0]  = s_axis.tdata;
              3'd4: psh_d[63:32] = s_axis.tdata;
              default: begin
                p_d       = {s_axis.tdata[7:0], psh_q};
                p_valid_d = 1'b1;
                p_last_d  = s_axis.tlast;
                bcnt_d    = 3'd0;
                state_d   = WAIT;
                if (s_axis.tlast)
                  win_cnt_d = '0;
                else if (!(&win_cnt_q))
                  win_cnt_d = win_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
              end
            endcase
          end
        end
      end
      WAIT: begin
        if (res_valid) state_d = RECV;
      end
      default: state_d = RECV;
    endcase
    // registered ready tracks the state we are entering
    tready_d = (state_d == RECV);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= RECV;
      bcnt_q      <= 3'd0;
      wsh_q       <= '0;
      psh_q       <= '0;
      w_q         <= '0;
      p_q         <= '0;
      w_valid_q   <= 1'b0;
      p_valid_q   <= 1'b0;
      p_last_q    <= 1'b0;
      win_cnt_q   <= '0;
      frame_err_q <= 1'b0;
      tready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      wsh_q       <= wsh_d;
      psh_q       <= psh_d;
      w_q         <= w_d;
      p_q         <= p_d;
      w_valid_q   <= w_valid_d;
      p_valid_q   <= p_valid_d;
      p_last_q    <= p_last_d;
      win_cnt_q   <= win_cnt_d;
      frame_err_q <= frame_err_d;
      tready_q    <= tready_d;
    end
  end

  assign s_axis.tready = tready_q;
  assign w         = w_q;
  assign w_valid   = w_valid_q;
  assign p         = p_q;
  assign p_valid   = p_valid_q;
  assign p_last    = p_last_q;
  assign win_cnt   = win_cnt_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_conv_feed.sv
// Directed bench for conv_feed.
// Drives stream windows, core result strobes and reset.
module tb_conv_feed;
  logic        clk;
  logic        rstn;
  logic        res_valid;
  logic [71:0] w, p;
  logic        w_valid, p_valid, p_last, frame_err;
  logic [15:0] win_cnt;

  int  checks;
  int  errors;
  int  wv_cnt;
  int  pv_cnt;
  time pv_t;
  time pv_prev;
  int  wv0, pv0;

  conv_feed_if s_axis ();

  conv_feed #(.CNT_W(16)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .s_axis    (s_axis.slave),
    .w         (w),
    .w_valid   (w_valid),
    .p         (p),
    .p_valid   (p_valid),
    .p_last    (p_last),
    .res_valid (res_valid),
    .win_cnt   (win_cnt),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (w_valid) wv_cnt <= wv_cnt + 1;
    if (p_valid) begin
      pv_prev <= pv_t;
      pv_t    <= $time;
      pv_cnt  <= pv_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [71:0] got,
                     input logic [71:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic l,
                      input bit gaps);
    int n;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        s_axis.tvalid = 1'b0;
        cyc(1);
      end
    end
    s_axis.tdata  = d;
    s_axis.tlast  = l;
    s_axis.tvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_axis.tready && n < 50);
    chk("tready_wait", 72'(s_axis.tready), 72'd1);
    @(posedge clk);
    #1;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  // six beats; checks both strobes and the packed vectors
  task automatic send6(input logic [31:0] d0, d1, d2, d3, d4, d5,
                       input logic l, input bit gaps,
                       input logic [15:0] exp_cnt);
    beat(d0, 1'b0, gaps);
    beat(d1, 1'b0, gaps);
    beat(d2, 1'b0, gaps);
    chk("w_valid", 72'(w_valid), 72'd1);
    chk("w", w, {d2[7:0], d1, d0});
    beat(d3, 1'b0, gaps);
    beat(d4, 1'b0, gaps);
    beat(d5, l, gaps);
    chk("p_valid", 72'(p_valid), 72'd1);
    chk("p_last", 72'(p_last), 72'(l));
    chk("p", p, {d5[7:0], d4, d3});
    chk("win_cnt", 72'(win_cnt), 72'(exp_cnt));
    chk("tready_pv", 72'(s_axis.tready), 72'd0);
  endtask

  task automatic resp(input int k);
    cyc(k);
    chk("tready_wait_res", 72'(s_axis.tready), 72'd0);
    res_valid = 1'b1;
    cyc(1);
    res_valid = 1'b0;
    chk("tready_rel", 72'(s_axis.tready), 72'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    wv_cnt = 0;
    pv_cnt = 0;
    pv_t = 0;
    pv_prev = 0;
    rstn = 1'b0;
    res_valid = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;

    // reset values
    cyc(2);
    chk("rst_tready", 72'(s_axis.tready), 72'd0);
    chk("rst_w", w, 72'd0);
    chk("rst_p", p, 72'd0);
    chk("rst_cnt", 72'(win_cnt), 72'd0);
    chk("rst_err", 72'(frame_err), 72'd0);
    @(negedge clk);
    rstn = 1'b1;
    cyc(1);
    chk("tready_up", 72'(s_axis.tready), 72'd1);

    // single window with tlast
    send6(32'h04030201, 32'h08070605, 32'hAAAAAA09,
          32'h01010101, 32'h01010101, 32'h00000001, 1'b1, 1'b0,
          16'd0);
    chk("w_const", w, 72'h090807060504030201);
    chk("p_const", p, 72'h010101010101010101);
    cyc(3);
    chk("tready_held", 72'(s_axis.tready), 72'd0);
    chk("w_valid_1cyc", 72'(w_valid | p_valid), 72'd0);
    resp(1);

    // three back-to-back windows, core answers 2 cycles later
    send6(32'h11111111, 32'h22222222, 32'h33333333,
          32'h44444444, 32'h55555555, 32'h66666666, 1'b0, 1'b0,
          16'd1);
    resp(2);
    send6(32'hDEADBEEF, 32'hCAFEF00D, 32'h000000A5,
          32'h12345678, 32'h9ABCDEF0, 32'hFFFFFF5A, 1'b0, 1'b0,
          16'd2);
    resp(2);
    chk("period12", 72'(pv_t - pv_prev), 72'd90);
    send6(32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 1'b1, 1'b0,
          16'd0);
    resp(2);
    chk("period23", 72'(pv_t - pv_prev), 72'd90);

    // tlast on beat 4: framing error, no p_valid
    pv0 = pv_cnt;
    beat(32'hA0A0A0A0, 1'b0, 1'b0);
    beat(32'hA1A1A1A1, 1'b0, 1'b0);
    beat(32'hA2A2A2A2, 1'b0, 1'b0);
    beat(32'hA3A3A3A3, 1'b0, 1'b0);
    beat(32'hA4A4A4A4, 1'b1, 1'b0);
    chk("ferr_set", 72'(frame_err), 72'd1);
    chk("ferr_tready", 72'(s_axis.tready), 72'd1);
    cyc(2);
    chk("ferr_no_pv", 72'(pv_cnt - pv0), 72'd0);
    send6(32'h04030201, 32'h08070605, 32'hAAAAAA09,
          32'h01010101, 32'h01010101, 32'h00000001, 1'b1, 1'b0,
          16'd0);
    chk("ferr_sticky", 72'(frame_err), 72'd1);
    resp(2);

    // random gaps: same vectors, one strobe each
    wv0 = wv_cnt;
    pv0 = pv_cnt;
    send6(32'h04030201, 32'h08070605, 32'hAAAAAA09,
          32'h01010101, 32'h01010101, 32'h00000001, 1'b1, 1'b1,
          16'd0);
    chk("gap_w", w, 72'h090807060504030201);
    chk("gap_p", p, 72'h010101010101010101);
    resp(2);
    chk("gap_wv_once", 72'(wv_cnt - wv0), 72'd1);
    chk("gap_pv_once", 72'(pv_cnt - pv0), 72'd1);

    // res_valid in RECV is ignored
    beat(32'h0, 1'b0, 1'b0);
    beat(32'h0, 1'b0, 1'b0);
    beat(32'h00000077, 1'b0, 1'b0);
    beat(32'h0, 1'b0, 1'b0);
    res_valid = 1'b1;
    cyc(1);
    res_valid = 1'b0;
    chk("recv_res_tready", 72'(s_axis.tready), 72'd1);
    beat(32'h0, 1'b0, 1'b0);
    beat(32'h000000EE, 1'b1, 1'b0);
    chk("recv_res_pv", 72'(p_valid), 72'd1);
    chk("recv_res_p", p, 72'hEE_00000000_00000000);
    cyc(2);
    chk("recv_res_wait", 72'(s_axis.tready), 72'd0);
    resp(1);

    // reset in the middle of beat 4
    beat(32'h04030201, 1'b0, 1'b0);
    beat(32'h08070605, 1'b0, 1'b0);
    beat(32'hAAAAAA09, 1'b0, 1'b0);
    beat(32'h01010101, 1'b0, 1'b0);
    s_axis.tdata  = 32'h01010101;
    s_axis.tvalid = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mid_rst_tready", 72'(s_axis.tready), 72'd0);
    chk("mid_rst_w", w, 72'd0);
    chk("mid_rst_p", p, 72'd0);
    chk("mid_rst_err", 72'(frame_err), 72'd0);
    chk("mid_rst_strb", 72'({w_valid, p_valid, p_last}), 72'd0);
    s_axis.tvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    cyc(1);
    chk("rel_tready", 72'(s_axis.tready), 72'd1);
    send6(32'h0C0B0A09, 32'h100F0E0D, 32'h00000011,
          32'h15141312, 32'h19181716, 32'h0000001A, 1'b1, 1'b0,
          16'd0);
    chk("rel_p_const", p, 72'h1A_19181716_15141312);
    resp(2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
